bus_txn_arbiter: RTL

Transaction-level arbiter for the shared 8-bit accelerator data bus. Sits between the engine FSMs (AES, SHA, one spare port) and the bus output register. Grants the bus round-robin and holds the grant for a whole transaction (until `last` or a burst cap), so byte streams from different engines never interleave mid-transaction.

---
 rtl/crypto_pkg.sv | 21 ++
 rtl/bus_txn_arbiter_rr_pick.sv | 33 +++
 rtl/bus_txn_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/crypto_pkg.sv
// crypto_pkg: control-path constants shared by the accelerator engines and bus arbitration.
// Holds requester indices, the arbiter state encoding and default burst length.
package crypto_pkg;

  localparam int REQ_AES   = 0;
  localparam int REQ_SHA   = 1;
  localparam int REQ_SPARE = 2;

  localparam int ARB_MAX_BURST_DEFAULT = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Index width that stays at least one bit wide for single-entry arbiters.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_txn_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; the first set req at or above rr_ptr
// (wrapping) wins, reported both one-hot and as an index.
module rr_pick
  import crypto_pkg::*;
#(
  parameter int N = 3,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [N-1:0] winner,
  output logic [W-1:0] winner_idx
);

  logic [W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    cand       = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr} + (W+1)'(off);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (req[cand[W-1:0]]) begin
        winner                 = '0;
        winner[cand[W-1:0]]    = 1'b1;
        winner_idx             = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_txn_arbiter.sv
// bus_txn_arbiter: round-robin transaction arbiter for the shared accelerator data bus.
// Define BUS_ARB_WATCHDOG_EN to add the stall watchdog and its err pulse output.
module bus_txn_arbiter
  import crypto_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int DATAW     = 8,
  parameter int MAX_BURST = ARB_MAX_BURST_DEFAULT,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            last,
  input  logic [NREQ*DATAW-1:0]      data_in,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            take,
  input  logic                       bus_ready,
  output logic [DATAW-1:0]           data_out,
  output logic                       valid_out,
  output logic [idx_width(NREQ)-1:0] owner,
  output logic                       busy
`ifdef BUS_ARB_WATCHDOG_EN
  ,
  output logic                       err
`endif
);

  localparam int OW = idx_width(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t      state;
  arb_state_t      state_next;
  logic [OW-1:0]   rr_ptr;
  logic [CW-1:0]   beat_cnt;
  logic [NREQ-1:0] pick;
  logic [OW-1:0]   pick_idx;
  logic            beat;
  logic            cap_hit;
  logic            force_end;
  logic            burst_end;

  if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("bus_txn_arbiter: MAX_BURST and TIMEOUT must be at least 1");
  end

  rr_pick #(
    .N (NREQ),
    .W (OW)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (pick),
    .winner_idx (pick_idx)
  );

  assign beat      = |take;
  assign cap_hit   = (beat_cnt == CW'(MAX_BURST - 1));
  assign burst_end = (beat && (last[owner] || cap_hit)) || force_end;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;

  // Consecutive no-take cycles of the current owner; any beat or release clears it.
  always_ff @(posedge clk) begin
    if (rst || state != ARB_GRANT || beat || force_end) stall_cnt <= '0;
    else stall_cnt <= stall_cnt + SW'(1);
  end

  assign force_end = (state == ARB_GRANT) && !beat && (stall_cnt == SW'(TIMEOUT - 1));
  assign err       = force_end;
`else
  assign force_end = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (|req) state_next = ARB_GRANT;
      ARB_GRANT: if (burst_end) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  // Grant, owner and pointer change only at arbitration and at burst end, never mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      beat_cnt <= '0;
      if (|req) begin
        grant <= pick;
        owner <= pick_idx;
      end
    end else if (burst_end) begin
      grant    <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
    end else if (beat) begin
      beat_cnt <= beat_cnt + CW'(1);
    end
  end

  always_comb begin
    busy      = (state == ARB_GRANT);
    take      = grant & req & {NREQ{bus_ready}};
    valid_out = busy && req[owner];
    data_out  = '0;
    if (busy) data_out = data_in[int'(owner)*DATAW +: DATAW];
  end

endmodule
